// File: rtl/lighthouse_ootx_decoder.sv
// Lighthouse OOTX side-channel decoder: turns one data bit per sync pulse into payload bytes and frame status.
// Optional build macro OOTX_CRC_EN enables the CRC-32 check of the frame trailer.
module lighthouse_ootx_decoder #(
  parameter int MAX_LEN  = 64,
  parameter int PREAMBLE = 17
) (
  input  logic        clk_48,
  input  logic        reset,
  input  logic        ootx_bit,
  input  logic        ootx_strobe,
  output logic [7:0]  byte_data,
  output logic        byte_strobe,
  output logic [15:0] frame_len,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        frame_error
);

  localparam int            ZW        = $clog2(PREAMBLE + 1);
  localparam logic [ZW-1:0] PRE_CNT   = ZW'(PREAMBLE);
  localparam logic [ZW-1:0] ZERO_ONE  = ZW'(1);
  localparam logic [ZW-1:0] ZERO_NONE = ZW'(0);
  localparam logic [15:0]   MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [4:0]    SYNC_POS  = 5'd16;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CRC     = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [ZW-1:0] zero_cnt_r, zero_cnt_s;
  logic [4:0]    bit_cnt_r, bit_cnt_s;
  logic [15:0]   word_r, word_s;
  logic [15:0]   byte_cnt_r, byte_cnt_s;
  logic          crc_word_r, crc_word_s;
  logic [15:0]   shifted_s;
  logic [15:0]   swapped_s;

  logic [7:0]    byte_data_s;
  logic          byte_strobe_s;
  logic [15:0]   frame_len_s;
  logic          frame_start_s;
  logic          frame_done_s;
  logic          frame_ok_s;
  logic          frame_error_s;

`ifdef OOTX_CRC_EN
  logic [31:0] crc_r, crc_s;
  logic [15:0] crc_lo_r, crc_lo_s;
  logic        crc_match_s;

  // One reflected CRC-32 byte step; the byte arrives MSB first, so it is folded in once complete.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ 32'hEDB8_8320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction
`endif

  // Next-state and next-output decode, evaluated on every ootx_strobe.
  always_comb begin
    state_s       = state_r;
    zero_cnt_s    = zero_cnt_r;
    bit_cnt_s     = bit_cnt_r;
    word_s        = word_r;
    byte_cnt_s    = byte_cnt_r;
    crc_word_s    = crc_word_r;
    byte_data_s   = byte_data;
    byte_strobe_s = 1'b0;
    frame_len_s   = frame_len;
    frame_start_s = 1'b0;
    frame_done_s  = 1'b0;
    frame_ok_s    = 1'b0;
    frame_error_s = 1'b0;
    shifted_s     = {word_r[14:0], ootx_bit};
    swapped_s     = {word_r[7:0], word_r[15:8]};
`ifdef OOTX_CRC_EN
    crc_s         = crc_r;
    crc_lo_s      = crc_lo_r;
    crc_match_s   = ({swapped_s, crc_lo_r} == ~crc_r);
`endif

    if (!ootx_strobe) begin
      state_s = state_r;
    end else if (state_r == HUNT) begin
      if (!ootx_bit) begin
        if (zero_cnt_r < PRE_CNT) begin
          zero_cnt_s = zero_cnt_r + ZERO_ONE;
        end else begin
          zero_cnt_s = zero_cnt_r;
        end
      end else begin
        zero_cnt_s = ZERO_NONE;
        if (zero_cnt_r >= PRE_CNT) begin
          state_s   = LEN;
          bit_cnt_s = 5'd0;
        end else begin
          state_s = HUNT;
        end
      end
    end else if (bit_cnt_r != SYNC_POS) begin
      word_s    = shifted_s;
      bit_cnt_s = bit_cnt_r + 5'd1;
      // Bit positions 7 and 15 close a byte; bytes past frame_len are the pad byte.
      if ((state_r == PAYLOAD) && (bit_cnt_r[2:0] == 3'd7)) begin
        byte_cnt_s = byte_cnt_r + 16'd1;
        if (byte_cnt_r < frame_len) begin
          byte_data_s   = shifted_s[7:0];
          byte_strobe_s = 1'b1;
`ifdef OOTX_CRC_EN
          crc_s         = crc32_byte(crc_r, shifted_s[7:0]);
`endif
        end else begin
          byte_strobe_s = 1'b0;
        end
      end else begin
        byte_cnt_s = byte_cnt_r;
      end
    end else if (!ootx_bit) begin
      // A bad sync bit is itself the first zero of the next preamble.
      frame_error_s = 1'b1;
      state_s       = HUNT;
      zero_cnt_s    = ZERO_ONE;
      bit_cnt_s     = 5'd0;
    end else begin
      bit_cnt_s = 5'd0;
      case (state_r)
        LEN: begin
          frame_len_s = swapped_s;
          if (swapped_s > MAX_LEN_W) begin
            frame_error_s = 1'b1;
            state_s       = HUNT;
          end else begin
            frame_start_s = 1'b1;
            byte_cnt_s    = 16'd0;
            crc_word_s    = 1'b0;
`ifdef OOTX_CRC_EN
            crc_s         = 32'hFFFF_FFFF;
`endif
            if (swapped_s == 16'd0) begin
              state_s = CRC;
            end else begin
              state_s = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (byte_cnt_r >= frame_len) begin
            state_s = CRC;
          end else begin
            state_s = PAYLOAD;
          end
        end
        CRC: begin
          if (!crc_word_r) begin
            crc_word_s = 1'b1;
`ifdef OOTX_CRC_EN
            crc_lo_s   = swapped_s;
`endif
          end else begin
            crc_word_s    = 1'b0;
            state_s       = HUNT;
            frame_done_s  = 1'b1;
`ifdef OOTX_CRC_EN
            frame_ok_s    = crc_match_s;
            frame_error_s = ~crc_match_s;
`else
            frame_ok_s    = 1'b1;
            frame_error_s = 1'b0;
`endif
          end
        end
        default: begin
          state_s = HUNT;
        end
      endcase
    end
  end

  // Control state and registered outputs; reset drops any frame in progress silently.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      state_r     <= HUNT;
      zero_cnt_r  <= ZERO_NONE;
      bit_cnt_r   <= 5'd0;
      word_r      <= 16'd0;
      byte_cnt_r  <= 16'd0;
      crc_word_r  <= 1'b0;
      byte_data   <= 8'd0;
      byte_strobe <= 1'b0;
      frame_len   <= 16'd0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_r     <= state_s;
      zero_cnt_r  <= zero_cnt_s;
      bit_cnt_r   <= bit_cnt_s;
      word_r      <= word_s;
      byte_cnt_r  <= byte_cnt_s;
      crc_word_r  <= crc_word_s;
      byte_data   <= byte_data_s;
      byte_strobe <= byte_strobe_s;
      frame_len   <= frame_len_s;
      frame_start <= frame_start_s;
      frame_done  <= frame_done_s;
      frame_ok    <= frame_ok_s;
      frame_error <= frame_error_s;
    end
  end

`ifdef OOTX_CRC_EN
  // Running payload CRC and the captured low half of the received CRC.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      crc_r    <= 32'hFFFF_FFFF;
      crc_lo_r <= 16'd0;
    end else begin
      crc_r    <= crc_s;
      crc_lo_r <= crc_lo_s;
    end
  end
`endif

endmodule

// File: tb/tb_lighthouse_ootx_decoder.sv
// Self-checking bench for lighthouse_ootx_decoder: frames are built from payload bytes and
// expected bytes/status come from a frame-level model with an independent MSB-first CRC-32.
module tb_lighthouse_ootx_decoder;

  localparam int MAX_LEN = 64;

  logic        clk_48 = 1'b0;
  logic        reset;
  logic        ootx_bit;
  logic        ootx_strobe;
  logic [7:0]  byte_data;
  logic        byte_strobe;
  logic [15:0] frame_len;
  logic        frame_start;
  logic        frame_done;
  logic        frame_ok;
  logic        frame_error;

  always #10 clk_48 = ~clk_48;

  lighthouse_ootx_decoder #(.MAX_LEN(MAX_LEN), .PREAMBLE(17)) dut (
    .clk_48      (clk_48),
    .reset       (reset),
    .ootx_bit    (ootx_bit),
    .ootx_strobe (ootx_strobe),
    .byte_data   (byte_data),
    .byte_strobe (byte_strobe),
    .frame_len   (frame_len),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .frame_error (frame_error)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic        strobe_seen = 1'b0;
  int          start_cnt = 0;
  int          done_cnt  = 0;
  int          ok_cnt    = 0;
  int          err_cnt   = 0;
  int          stray_cnt = 0;
  logic [15:0] seen_len  = 16'd0;
  logic [7:0]  mon_bytes[$];
  logic [7:0]  pay[$];
  logic        wire_bits[$];

  // Remember whether the edge just passed sampled a strobe.
  always @(posedge clk_48) strobe_seen <= ootx_strobe;

  // Event monitor: collects output pulses; any pulse not right after a strobe edge is stray.
  always @(negedge clk_48) begin
    if (byte_strobe) mon_bytes.push_back(byte_data);
    if (frame_start) begin
      start_cnt <= start_cnt + 1;
      seen_len  <= frame_len;
    end
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      if (frame_ok) ok_cnt <= ok_cnt + 1;
    end
    if (frame_error) err_cnt <= err_cnt + 1;
    if ((byte_strobe || frame_start || frame_done || frame_error) && !strobe_seen)
      stray_cnt <= stray_cnt + 1;
  end

  task automatic send_bit(input logic b);
    @(negedge clk_48);
    ootx_bit    = b;
    ootx_strobe = 1'b1;
    @(negedge clk_48);
    ootx_strobe = 1'b0;
    @(negedge clk_48);
  endtask

  task automatic send_all();
    while (wire_bits.size() > 0) send_bit(wire_bits.pop_front());
    repeat (2) @(negedge clk_48);
  endtask

  task automatic push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) wire_bits.push_back(w[i]);
    wire_bits.push_back(1'b1);
  endtask

  task automatic push_le16(input logic [15:0] v);
    push_word({v[7:0], v[15:8]});
  endtask

  task automatic push_preamble(input int zeros);
    for (int i = 0; i < zeros; i++) wire_bits.push_back(1'b0);
    wire_bits.push_back(1'b1);
  endtask

  // CRC-32/IEEE as non-reflected MSB-first shifting over bit-reversed bytes, result reflected back.
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] s;
    logic [31:0] r;
    logic [7:0]  d;
    logic        fb;
    s = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      d = pay[i];
      for (int k = 0; k < 8; k++) begin
        fb = s[31] ^ d[k];
        s  = {s[30:0], 1'b0};
        if (fb) s = s ^ 32'h04C1_1DB7;
      end
    end
    for (int j = 0; j < 32; j++) r[j] = s[31 - j];
    return r ^ 32'hFFFF_FFFF;
  endfunction

  task automatic fill_pay(input int len);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic build_frame(input int len, input logic [31:0] crc_flip);
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [31:0] crc;
    push_preamble(17);
    push_le16(16'(len));
    for (int w = 0; w < (len + 1) / 2; w++) begin
      hi = pay[2*w];
      if (2*w + 1 < len) lo = pay[2*w + 1];
      else lo = 8'h00;
      push_word({hi, lo});
    end
    crc = ref_crc(len) ^ crc_flip;
    push_le16(crc[15:0]);
    push_le16(crc[31:16]);
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    ootx_bit    = 1'b0;
    ootx_strobe = 1'b0;
    repeat (3) @(negedge clk_48);
    tests_run++;
    if ({byte_data, byte_strobe, frame_len, frame_start, frame_done, frame_ok, frame_error} !== 29'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h len=%h, required all zero", byte_data, frame_len);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk_48);
  endtask

  task automatic test_reset_race();
    int s0;
    s0 = start_cnt;
    for (int i = 0; i < 17; i++) send_bit(1'b0);
    @(negedge clk_48);
    reset       = 1'b1;
    ootx_bit    = 1'b1;
    ootx_strobe = 1'b1;
    @(negedge clk_48);
    reset       = 1'b0;
    ootx_strobe = 1'b0;
    push_le16(16'h0000);
    push_le16(16'h0000);
    push_le16(16'h0000);
    send_all();
    tests_run++;
    if (start_cnt - s0 !== 0) begin
      tests_failed++;
      $display("FAIL reset_race_start: got %0d frame_start, required 0", start_cnt - s0);
    end
  endtask

  task automatic test_basic();
    int s0, d0, o0, e0, y0, b0;
    s0 = start_cnt; d0 = done_cnt; o0 = ok_cnt; e0 = err_cnt; y0 = stray_cnt; b0 = mon_bytes.size();
    pay.delete();
    pay.push_back(8'hAB);
    pay.push_back(8'hCD);
    build_frame(2, 32'd0);
    send_all();
    tests_run++;
    if (mon_bytes.size() - b0 !== 2) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d bytes, required 2", mon_bytes.size() - b0);
    end else begin
      tests_run++;
      if (mon_bytes[b0] !== 8'hAB || mon_bytes[b0 + 1] !== 8'hCD) begin
        tests_failed++;
        $display("FAIL basic_bytes: got %h %h, required ab cd", mon_bytes[b0], mon_bytes[b0 + 1]);
      end
    end
    tests_run++;
    if (start_cnt - s0 !== 1 || seen_len !== 16'd2) begin
      tests_failed++;
      $display("FAIL basic_start: got %0d starts len %0d, required 1 start len 2", start_cnt - s0, seen_len);
    end
    tests_run++;
    if (frame_len !== 16'd2) begin
      tests_failed++;
      $display("FAIL basic_len_hold: got %0d, required 2", frame_len);
    end
    tests_run++;
    if (done_cnt - d0 !== 1 || ok_cnt - o0 !== 1 || err_cnt - e0 !== 0) begin
      tests_failed++;
      $display("FAIL basic_done: got done=%0d ok=%0d err=%0d, required 1 1 0",
               done_cnt - d0, ok_cnt - o0, err_cnt - e0);
    end
    tests_run++;
    if (stray_cnt - y0 !== 0) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d stray pulses, required 0", stray_cnt - y0);
    end
  endtask

  task automatic test_random_frames();
    int fixed_lens[4] = '{0, 1, 63, 64};
    int len, s0, d0, o0, e0, y0, b0, bad;
    for (int f = 0; f < 8; f++) begin
      if (f < 4) len = fixed_lens[f];
      else len = $urandom_range(1, MAX_LEN);
      fill_pay(len);
      s0 = start_cnt; d0 = done_cnt; o0 = ok_cnt; e0 = err_cnt; y0 = stray_cnt; b0 = mon_bytes.size();
      build_frame(len, 32'd0);
      send_all();
      tests_run++;
      if (mon_bytes.size() - b0 !== len) begin
        tests_failed++;
        $display("FAIL rand_count: len %0d got %0d bytes, required %0d", len, mon_bytes.size() - b0, len);
      end else begin
        bad = 0;
        for (int i = 0; i < len; i++) if (mon_bytes[b0 + i] !== pay[i]) bad++;
        tests_run++;
        if (bad != 0) begin
          tests_failed++;
          $display("FAIL rand_bytes: len %0d got %0d wrong bytes, required 0", len, bad);
        end
      end
      tests_run++;
      if (start_cnt - s0 !== 1 || seen_len !== 16'(len)) begin
        tests_failed++;
        $display("FAIL rand_start: got %0d starts len %0d, required 1 len %0d", start_cnt - s0, seen_len, len);
      end
      tests_run++;
      if (done_cnt - d0 !== 1 || ok_cnt - o0 !== 1 || err_cnt - e0 !== 0 || stray_cnt - y0 !== 0) begin
        tests_failed++;
        $display("FAIL rand_done: len %0d got done=%0d ok=%0d err=%0d stray=%0d, required 1 1 0 0",
                 len, done_cnt - d0, ok_cnt - o0, err_cnt - e0, stray_cnt - y0);
      end
    end
  endtask

  task automatic test_no_preamble();
    int s0, b0;
    s0 = start_cnt; b0 = mon_bytes.size();
    push_preamble(16);
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) wire_bits.push_back(1'b1);
      else wire_bits.push_back(1'($urandom_range(0, 1)));
    end
    send_all();
    tests_run++;
    if (start_cnt - s0 !== 0 || mon_bytes.size() - b0 !== 0) begin
      tests_failed++;
      $display("FAIL short_preamble: got %0d starts %0d bytes, required 0 0", start_cnt - s0, mon_bytes.size() - b0);
    end
  endtask

  task automatic test_bad_sync();
    int s0, d0, o0, e0, b0;
    s0 = start_cnt; e0 = err_cnt; b0 = mon_bytes.size();
    push_preamble(17);
    push_word(16'h0400);
    void'(wire_bits.pop_back());
    wire_bits.push_back(1'b0);
    send_all();
    tests_run++;
    if (err_cnt - e0 !== 1 || start_cnt - s0 !== 0 || mon_bytes.size() - b0 !== 0) begin
      tests_failed++;
      $display("FAIL bad_sync: got err=%0d starts=%0d bytes=%0d, required 1 0 0",
               err_cnt - e0, start_cnt - s0, mon_bytes.size() - b0);
    end
    s0 = start_cnt; d0 = done_cnt; o0 = ok_cnt;
    push_preamble(16);
    push_le16(16'h0000);
    push_le16(16'h0000);
    push_le16(16'h0000);
    send_all();
    tests_run++;
    if (start_cnt - s0 !== 1 || done_cnt - d0 !== 1 || ok_cnt - o0 !== 1) begin
      tests_failed++;
      $display("FAIL sync_zero_counts: got starts=%0d done=%0d ok=%0d, required 1 1 1",
               start_cnt - s0, done_cnt - d0, ok_cnt - o0);
    end
  endtask

  task automatic test_odd_len();
    int s0, o0, e0, b0;
    o0 = ok_cnt; b0 = mon_bytes.size();
    pay.delete();
    pay.push_back(8'h11);
    pay.push_back(8'h22);
    pay.push_back(8'h33);
    build_frame(3, 32'd0);
    send_all();
    tests_run++;
    if (mon_bytes.size() - b0 !== 3) begin
      tests_failed++;
      $display("FAIL odd_count: got %0d bytes, required 3", mon_bytes.size() - b0);
    end else begin
      tests_run++;
      if (mon_bytes[b0] !== 8'h11 || mon_bytes[b0 + 1] !== 8'h22 || mon_bytes[b0 + 2] !== 8'h33) begin
        tests_failed++;
        $display("FAIL odd_bytes: got %h %h %h, required 11 22 33", mon_bytes[b0], mon_bytes[b0 + 1], mon_bytes[b0 + 2]);
      end
    end
    tests_run++;
    if (ok_cnt - o0 !== 1) begin
      tests_failed++;
      $display("FAIL odd_ok: got %0d, required 1", ok_cnt - o0);
    end
    s0 = start_cnt; e0 = err_cnt;
    push_preamble(17);
    push_le16(16'd65);
    send_all();
    tests_run++;
    if (err_cnt - e0 !== 1 || start_cnt - s0 !== 0) begin
      tests_failed++;
      $display("FAIL len_too_big: got err=%0d starts=%0d, required 1 0", err_cnt - e0, start_cnt - s0);
    end
  endtask

  task automatic test_crc_flip();
    int d0, o0, e0;
    d0 = done_cnt; o0 = ok_cnt; e0 = err_cnt;
    pay.delete();
    pay.push_back(8'hAB);
    pay.push_back(8'hCD);
    build_frame(2, 32'h0000_0001);
    send_all();
    tests_run++;
`ifdef OOTX_CRC_EN
    if (done_cnt - d0 !== 1 || ok_cnt - o0 !== 0 || err_cnt - e0 !== 1) begin
      tests_failed++;
      $display("FAIL crc_flip: got done=%0d ok=%0d err=%0d, required 1 0 1", done_cnt - d0, ok_cnt - o0, err_cnt - e0);
    end
`else
    if (done_cnt - d0 !== 1 || ok_cnt - o0 !== 1 || err_cnt - e0 !== 0) begin
      tests_failed++;
      $display("FAIL crc_flip: got done=%0d ok=%0d err=%0d, required 1 1 0", done_cnt - d0, ok_cnt - o0, err_cnt - e0);
    end
`endif
  endtask

  task automatic test_reset_midframe();
    int d0, e0, b0;
    d0 = done_cnt; e0 = err_cnt; b0 = mon_bytes.size();
    pay.delete();
    pay.push_back(8'hAB);
    pay.push_back(8'hCD);
    build_frame(2, 32'd0);
    for (int i = 0; i < 43; i++) send_bit(wire_bits.pop_front());
    @(negedge clk_48);
    reset = 1'b1;
    @(negedge clk_48);
    tests_run++;
    if ({byte_data, byte_strobe, frame_len, frame_start, frame_done, frame_ok, frame_error} !== 29'd0) begin
      tests_failed++;
      $display("FAIL midframe_reset: got byte=%h len=%h, required all zero", byte_data, frame_len);
    end
    reset = 1'b0;
    send_all();
    tests_run++;
    if (mon_bytes.size() - b0 !== 1 || done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      tests_failed++;
      $display("FAIL midframe_abandon: got bytes=%0d done=%0d err=%0d, required 1 0 0",
               mon_bytes.size() - b0, done_cnt - d0, err_cnt - e0);
    end else begin
      tests_run++;
      if (mon_bytes[b0] !== 8'hAB) begin
        tests_failed++;
        $display("FAIL midframe_first_byte: got %h, required ab", mon_bytes[b0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_race();
    test_basic();
    test_random_frames();
    test_no_preamble();
    test_bad_sync();
    test_odd_len();
    test_crc_flip();
    test_reset_midframe();
    test_basic();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
